// File: rtl/plot_sink.sv
// Receiving end of the pixel-plot interface: range-checked plot FIFO feeding a
// 160x120x3 framebuffer RAM, with readback, hardware clear sweep and status counters.
module plot_sink #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  vga_x,
  input  logic [6:0]  vga_y,
  input  logic [2:0]  vga_colour,
  input  logic        vga_plot,
  input  logic        rd_req,
  input  logic [7:0]  rd_x,
  input  logic [6:0]  rd_y,
  output logic        rd_valid,
  output logic [2:0]  rd_colour,
  input  logic        clr_start,
  input  logic [2:0]  clr_colour,
  output logic        clr_done,
  output logic [15:0] pix_count,
  output logic [7:0]  drop_count,
  output logic        overflow
);

  localparam int          PW   = $clog2(FIFO_DEPTH);
  localparam int          NPIX = WIDTH * HEIGHT;
  localparam logic [14:0] LAST = 15'(NPIX - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, CDONE} state_t;

  state_t      state;
  logic [14:0] clr_cnt;
  logic [2:0]  clr_val;

  // y*160 + x as shifts and adds
  function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
  endfunction

  // Plot FIFO: entries are {addr, colour}; pointers carry a wrap bit
  logic [17:0] fifo_mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic [17:0] head;
  logic        empty, full;
  logic        plot_in_range, push, pop, drop, ovf_drop;
  logic        clr_we, rd_issue, rd_ok, rd_ok_q;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = fifo_mem[rd_ptr[PW-1:0]];

  assign plot_in_range = vga_plot && (int'(vga_x) < WIDTH) && (int'(vga_y) < HEIGHT);
  assign rd_ok         = (int'(rd_x) < WIDTH) && (int'(rd_y) < HEIGHT);

  // Clear write beats readback, readback beats drain
  assign clr_we   = (state == CLEAR);
  assign rd_issue = rd_req && !clr_we;
  assign pop      = !empty && !clr_we && !rd_issue;
  assign push     = plot_in_range && (!full || pop);
  assign drop     = vga_plot && !push;
  assign ovf_drop = plot_in_range && full && !pop;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= {pix_addr(vga_x, vga_y), vga_colour};
  end

  // Single-port framebuffer RAM
  logic [2:0]  mem [NPIX];
  logic [2:0]  ram_q;
  logic        ram_we, ram_re;
  logic [14:0] ram_addr;
  logic [2:0]  ram_wdata;

  always_comb begin
    ram_we    = clr_we || pop;
    ram_re    = rd_issue && rd_ok;
    ram_wdata = clr_we ? clr_val : head[2:0];
    if (clr_we)        ram_addr = clr_cnt;
    else if (rd_issue) ram_addr = pix_addr(rd_x, rd_y);
    else               ram_addr = head[17:3];
  end

  always_ff @(posedge clk) begin
    if (ram_we)      mem[ram_addr] <= ram_wdata;
    else if (ram_re) ram_q <= mem[ram_addr];
  end

  assign rd_colour = rd_ok_q ? ram_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_valid   <= 1'b0;
      rd_ok_q    <= 1'b0;
      pix_count  <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      rd_valid <= rd_issue;
      rd_ok_q  <= rd_issue && rd_ok;
      if (pop && pix_count != '1)   pix_count  <= pix_count + 1'b1;
      if (drop && drop_count != '1) drop_count <= drop_count + 1'b1;
      if (ovf_drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      clr_val  <= '0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (clr_start) begin
          state   <= CLEAR;
          clr_val <= clr_colour;
          clr_cnt <= '0;
        end
        CLEAR: if (clr_cnt == LAST) begin
          state    <= CDONE;
          clr_done <= 1'b1;
        end else begin
          clr_cnt <= clr_cnt + 1'b1;
        end
        CDONE: if (!clr_start) begin
          state    <= IDLE;
          clr_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
